// File: rtl/pxie_c2h_read_ctrl.sv
// Card-to-host readback sequencer: emits a header beat, then streams RAM words
// to the PXIE TX stream through a credit-managed output FIFO.
module pxie_c2h_read_ctrl #(
   parameter int          RAM_LAT    = 2,
   parameter int          FIFO_DEPTH = 8,
   parameter int          ADDR_STEP  = 2,
   parameter logic [15:0] HDR_TAG    = 16'hEB9C
) (
   input  logic        I_PXIE_CLK,
   input  logic        I_Rst,
   input  logic        I_c2h_en,
   input  logic [15:0] I_c2h_addr,
   input  logic [15:0] I_c2h_len,
   output logic        O_ram_rden,
   output logic [31:0] O_ram_addr,
   input  logic [63:0] I_ram_data,
   output logic [63:0] O_tx_data,
   output logic        O_tx_vld,
   input  logic        I_tx_rdy,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_drop
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(RAM_LAT + 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_READ, S_DRAIN, S_DONE} state_t;

   state_t             r_state;
   logic [15:0]        r_len;
   logic [15:0]        r_addr;
   logic [15:0]        r_issued;
   logic [31:0]        r_raddr;
   logic [RAM_LAT-1:0] r_rd_pipe;
   logic [63:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [CW-1:0]      r_cnt;
   logic               r_drop;

   logic [IW-1:0]      w_inflight;
   logic               w_empty, w_full, w_pop, w_tap;
   logic               w_hdr_push, w_push, w_credit, w_issue, w_last_out;
   logic [63:0]        w_push_data;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RAM_LAT; i++)
         w_inflight = w_inflight + IW'(r_rd_pipe[i]);
   end

   assign w_empty     = (r_cnt == '0);
   assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
   assign w_pop       = !w_empty && I_tx_rdy;
   assign w_tap       = r_rd_pipe[RAM_LAT-1];
   assign w_hdr_push  = (r_state == S_HDR) && !w_full;
   assign w_push      = w_hdr_push || w_tap;
   assign w_push_data = w_tap ? I_ram_data : {HDR_TAG, r_len, 16'h0000, r_addr};
   // Reads in flight already own a FIFO slot, so a returning word can never hit a full FIFO.
   assign w_credit    = (32'(r_cnt) + 32'(w_inflight) + 32'd1) <= 32'(FIFO_DEPTH);
   assign w_issue     = (r_state == S_READ) && (r_issued != r_len) && w_credit;
   assign w_last_out  = (w_inflight == '0) && (w_empty || ((r_cnt == CW'(1)) && w_pop));

   always_ff @(posedge I_PXIE_CLK) begin
      if (w_push) r_mem[r_wptr] <= w_push_data;
   end

   always_ff @(posedge I_PXIE_CLK) begin
      if (I_Rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
         r_rd_pipe <= '0;
      end else begin
         r_rd_pipe <= RAM_LAT'({r_rd_pipe, w_issue});
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge I_PXIE_CLK) begin
      if (I_Rst) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_addr   <= '0;
         r_issued <= '0;
         r_raddr  <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_drop <= I_c2h_en && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: if (I_c2h_en) begin
               r_len    <= I_c2h_len;
               r_addr   <= I_c2h_addr;
               r_raddr  <= {16'h0000, I_c2h_addr};
               r_issued <= '0;
               r_state  <= S_HDR;
            end
            S_HDR: if (!w_full) r_state <= (r_len == '0) ? S_DRAIN : S_READ;
            S_READ: begin
               if (w_issue) begin
                  r_issued <= r_issued + 16'd1;
                  r_raddr  <= r_raddr + 32'(ADDR_STEP);
               end else if (r_issued == r_len) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: if (w_last_out) r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign O_ram_rden = w_issue;
   assign O_ram_addr = w_issue ? r_raddr : 32'h0;
   assign O_tx_vld   = !w_empty;
   assign O_tx_data  = w_empty ? 64'h0 : r_mem[r_rptr];
   assign O_busy     = (r_state == S_HDR) || (r_state == S_READ) || (r_state == S_DRAIN);
   assign O_done     = (r_state == S_DONE);
   assign O_drop     = r_drop;
endmodule

// File: tb/tb_pxie_c2h_read_ctrl.sv
// Directed bench for pxie_c2h_read_ctrl: RAM model with fixed latency, beat and
// read-address logging, hand-derived expected sequences.
module tb_pxie_c2h_read_ctrl;
   localparam int RAM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] c_addr = '0;
   logic [15:0] c_len = '0;
   logic        rden;
   logic [31:0] raddr;
   logic [63:0] ram_data;
   logic [63:0] tx_data;
   logic        tx_vld;
   logic        tx_rdy = 1'b1;
   logic        busy, done, drop;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pxie_c2h_read_ctrl dut (
      .I_PXIE_CLK(clk), .I_Rst(rst), .I_c2h_en(en), .I_c2h_addr(c_addr),
      .I_c2h_len(c_len), .O_ram_rden(rden), .O_ram_addr(raddr),
      .I_ram_data(ram_data), .O_tx_data(tx_data), .O_tx_vld(tx_vld),
      .I_tx_rdy(tx_rdy), .O_busy(busy), .O_done(done), .O_drop(drop)
   );

   function automatic logic [63:0] ram_word(input logic [31:0] a);
      return {~a, a};
   endfunction

   function automatic logic [63:0] hdr(input logic [15:0] a, input logic [15:0] l);
      return {16'hEB9C, l, 16'h0000, a};
   endfunction

   // RAM read port: data valid RAM_LAT cycles after rden
   logic [31:0] rq_a [RAM_LAT] = '{default: 32'h0};
   logic        rq_v [RAM_LAT] = '{default: 1'b0};
   always @(posedge clk) begin
      rq_v[0] <= rden;
      rq_a[0] <= raddr;
      for (int i = 1; i < RAM_LAT; i++) begin
         rq_v[i] <= rq_v[i-1];
         rq_a[i] <= rq_a[i-1];
      end
   end
   assign ram_data = rq_v[RAM_LAT-1] ? ram_word(rq_a[RAM_LAT-1]) : 64'hBAD0_BAD0_BAD0_BAD0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   logic [63:0] beats [$];
   int          beat_cyc [$];
   logic [31:0] rd_addr [$];
   int          rd_cyc [$];
   int          done_cnt = 0;
   int          drop_cnt = 0;
   int          done_cyc = 0;
   logic        p_stall = 1'b0;
   logic [63:0] p_data = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_vld && tx_rdy) begin beats.push_back(tx_data); beat_cyc.push_back(cyc); end
         if (rden) begin rd_addr.push_back(raddr); rd_cyc.push_back(cyc); end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (drop) drop_cnt++;
         if (p_stall) chk("stall_hold", tx_data, p_data);
      end
      p_stall = !rst && tx_vld && !tx_rdy;
      p_data  = tx_data;
   end

   task automatic clear();
      beats.delete(); beat_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
      done_cnt = 0; drop_cnt = 0;
   endtask

   task automatic req(input logic [15:0] a, input logic [15:0] l);
      en = 1'b1; c_addr = a; c_len = l;
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (done_cnt == 0 && n < maxc) begin @(posedge clk); #1; n++; end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
      repeat (4) begin @(posedge clk); #1; end
      chk("done_once", 64'(done_cnt), 64'd1);
   endtask

   task automatic check_beats(input string tag, input logic [63:0] exp [$]);
      chk({tag, "_nbeats"}, 64'(beats.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < beats.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), beats[i], exp[i]);
   endtask

   task automatic check_rd(input string tag, input logic [31:0] exp [$]);
      chk({tag, "_nrd"}, 64'(rd_addr.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < rd_addr.size(); i++)
         chk($sformatf("%s_rd%0d", tag, i), 64'(rd_addr[i]), 64'(exp[i]));
   endtask

   logic [63:0] eb [$];
   logic [31:0] ea [$];

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", {59'h0, tx_vld, busy, done, drop, rden}, 64'h0);
      chk("rst_txd", tx_data, 64'h0);
      chk("rst_raddr", 64'(raddr), 64'h0);
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // len=4 at 0x10, full-rate sink, latency checks
      clear();
      req(16'h0010, 16'd4);
      chk("t1_busy_hdr", {62'h0, busy, tx_vld}, 64'h2);
      @(posedge clk); #1;
      chk("t1_hdr_vis", {62'h0, tx_vld, rden}, 64'h3);
      chk("t1_hdr_data", tx_data, hdr(16'h0010, 16'd4));
      chk("t1_first_addr", 64'(raddr), 64'h10);
      wait_done(100);
      eb = '{hdr(16'h0010, 16'd4), ram_word(32'h10), ram_word(32'h12), ram_word(32'h14), ram_word(32'h16)};
      check_beats("t1", eb);
      ea = '{32'h10, 32'h12, 32'h14, 32'h16};
      check_rd("t1", ea);
      if (rd_cyc.size() == 4) chk("t1_rd_span", 64'(rd_cyc[3] - rd_cyc[0]), 64'd3);
      if (beat_cyc.size() >= 2) chk("t1_data_lat", 64'(beat_cyc[1] - beat_cyc[0]), 64'd3);

      // len=0: header only
      clear();
      req(16'h0020, 16'd0);
      wait_done(50);
      eb = '{hdr(16'h0020, 16'd0)};
      check_beats("t2", eb);
      chk("t2_nrd", 64'(rd_addr.size()), 64'd0);
      if (beat_cyc.size() == 1) chk("t2_done_gap", 64'(done_cyc - beat_cyc[0]), 64'd1);

      // len=16 with sink stalled for 20 cycles
      clear();
      tx_rdy = 1'b0;
      req(16'h0200, 16'd16);
      repeat (20) begin @(posedge clk); #1; end
      chk("t3_stall_nrd", 64'(rd_addr.size()), 64'd7);
      chk("t3_stall_vld", {63'h0, tx_vld}, 64'h1);
      chk("t3_stall_head", tx_data, hdr(16'h0200, 16'd16));
      tx_rdy = 1'b1;
      wait_done(200);
      eb = '{hdr(16'h0200, 16'd16)};
      for (int i = 0; i < 16; i++) eb.push_back(ram_word(32'h200 + 32'(2 * i)));
      check_beats("t3", eb);

      // second request during len=8 transfer is dropped
      clear();
      req(16'h0300, 16'd8);
      repeat (3) begin @(posedge clk); #1; end
      req(16'h0777, 16'd5);
      wait_done(100);
      chk("t4_drop", 64'(drop_cnt), 64'd1);
      eb = '{hdr(16'h0300, 16'd8)};
      for (int i = 0; i < 8; i++) eb.push_back(ram_word(32'h300 + 32'(2 * i)));
      check_beats("t4", eb);

      // reset mid-READ, then a clean len=2 request
      clear();
      req(16'h0400, 16'd10);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_rst_ctl", {59'h0, tx_vld, busy, done, drop, rden}, 64'h0);
      chk("t5_rst_txd", tx_data, 64'h0);
      clear();
      req(16'h0100, 16'd2);
      wait_done(50);
      eb = '{hdr(16'h0100, 16'd2), ram_word(32'h100), ram_word(32'h102)};
      check_beats("t5", eb);
      ea = '{32'h100, 32'h102};
      check_rd("t5", ea);

      // address carries past 16 bits
      clear();
      req(16'hFFFF, 16'd2);
      wait_done(50);
      ea = '{32'h0000FFFF, 32'h00010001};
      check_rd("t6", ea);
      eb = '{hdr(16'hFFFF, 16'd2), ram_word(32'h0000FFFF), ram_word(32'h00010001)};
      check_beats("t6", eb);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
